// File: rtl/prod_accum_pkg.sv
// Shared types and width helpers for the product accumulator.
package prod_accum_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // Bits needed to hold the value v (at least one).
  function automatic int bit_width(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prod_accum_tag_delay_line.sv
// Purpose: fixed-depth enabled shift register keeping sideband tags aligned with the multiplier pipe.
// Latency: DEPTH cycles of en_i=1.
// Backpressure: en_i=0 freezes every stage, mirroring the multiplier stall.
module tag_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/prod_accum.sv
// Purpose: accumulate multiplier products into groups, round/shift each sum (clamp under PROD_ACCUM_SAT_EN).
// Latency: out_valid_o rises MUL_LATENCY+1 cycles after the closing operands enter the multiplier.
// Backpressure: stall_o = out_valid_o & ~out_ready_i freezes multiplier, tag line, accumulator and output.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int P_WIDTH     = 20,
  parameter int MUL_LATENCY = 4,
  parameter int ACC_LEN     = 16,
  parameter int SHIFT       = 4,
  parameter int OUT_WIDTH   = 16,
  localparam int CW         = bit_width(ACC_LEN)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  input  logic [P_WIDTH-1:0]   data_p_i,
  output logic                 stall_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o,
  output logic [CW-1:0]        count_o
);

  localparam int ACC_WIDTH = P_WIDTH + CW;
  localparam int RND_SH    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RND_SH) : (ACC_WIDTH+1)'(0);

  tag_t tag_in, tag_al;
  logic stall, fire, close;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic [CW-1:0]        count_q, count_d, count_inc;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] data_q, data_d, res_dat;
  logic                 sat_q, sat_d, res_sat;
  logic [CW-1:0]        cnt_out_q, cnt_out_d;
  logic [ACC_WIDTH:0]   rounded;

  // A last flag only matters when it rides on a valid operand pair.
  always_comb begin
    tag_in      = '0;
    tag_in.vld  = in_valid_i;
    tag_in.last = in_valid_i & in_last_i;
  end

  tag_delay_line #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (MUL_LATENCY)
  ) u_tag_delay (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (~stall),
    .d_i     (tag_in),
    .q_o     (tag_al)
  );

  assign stall     = out_valid_q & ~out_ready_i;
  assign fire      = tag_al.vld & ~stall;
  assign count_inc = count_q + CW'(1);
  assign close     = tag_al.last | (count_inc == CW'(ACC_LEN));

  always_comb begin
    sum     = ((state_q == ST_IDLE) ? '0 : acc_q) + ACC_WIDTH'(data_p_i);
    rounded = ({1'b0, sum} + RND) >> SHIFT;
  end

`ifdef PROD_ACCUM_SAT_EN
  localparam int RW = max_int(ACC_WIDTH + 1, OUT_WIDTH + 1);
  logic [RW-1:0] r_ext;

  always_comb begin
    r_ext   = RW'(rounded);
    res_sat = (r_ext > RW'({OUT_WIDTH{1'b1}}));
    res_dat = res_sat ? '1 : OUT_WIDTH'(r_ext);
  end
`else
  assign res_sat = 1'b0;
  assign res_dat = OUT_WIDTH'(rounded);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    sat_d       = sat_q;
    cnt_out_d   = cnt_out_q;

    if (out_valid_q & out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // A closing group in a transfer cycle reloads the register back-to-back.
    if (fire) begin
      if (close) begin
        out_valid_d = 1'b1;
        data_d      = res_dat;
        sat_d       = res_sat;
        cnt_out_d   = count_inc;
        acc_d       = '0;
        count_d     = '0;
        state_d     = ST_IDLE;
      end else begin
        acc_d   = sum;
        count_d = count_inc;
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sat_q       <= 1'b0;
      cnt_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
      cnt_out_q   <= cnt_out_d;
    end
  end

  assign stall_o     = stall;
  assign out_valid_o = out_valid_q;
  assign data_o      = data_q;
  assign sat_o       = sat_q;
  assign count_o     = cnt_out_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: stall-aware multiplier pipe model, group-sum reference queue, directed and random traffic.
module tb_prod_accum;

  localparam int P_WIDTH     = 20;
  localparam int MUL_LATENCY = 4;
  localparam int ACC_LEN     = 4;
  localparam int SHIFT       = 4;
  localparam int OUT_WIDTH   = 16;
  localparam int CW          = $clog2(ACC_LEN + 1);

  logic                 clk_i = 1'b0;
  logic                 reset_i = 1'b0;
  logic                 in_valid_i = 1'b0;
  logic                 in_last_i = 1'b0;
  logic [P_WIDTH-1:0]   data_p_i = '0;
  logic                 stall_o;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b1;
  logic [OUT_WIDTH-1:0] data_o;
  logic                 sat_o;
  logic [CW-1:0]        count_o;

  prod_accum #(
    .P_WIDTH     (P_WIDTH),
    .MUL_LATENCY (MUL_LATENCY),
    .ACC_LEN     (ACC_LEN),
    .SHIFT       (SHIFT),
    .OUT_WIDTH   (OUT_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .data_p_i    (data_p_i),
    .stall_o     (stall_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .sat_o       (sat_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint data;
    longint sat;
    longint cnt;
  } res_t;

  int     checks = 0;
  int     errors = 0;
  res_t   exp_q[$];
  longint grp_sum = 0;
  int     grp_cnt = 0;
  logic [P_WIDTH-1:0] pipe [MUL_LATENCY];
  logic [P_WIDTH-1:0] op_prod = '0;
  int     cyc = 0;
  int     xfers = 0;
  int     accept_cyc = 0;
  int     last_xfer_cyc = 0;
  longint last_data = 0, last_sat = 0, last_cnt = 0;
  bit     accepted = 0;
  bit     rand_ready = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic res_t make_res(input longint sum, input int cnt);
    res_t   r;
    longint v;
    longint lim;
    lim = (64'd1 << OUT_WIDTH) - 1;
    v   = (SHIFT > 0) ? ((sum + (64'd1 << (SHIFT - 1))) >> SHIFT) : sum;
    r.cnt = cnt;
`ifdef PROD_ACCUM_SAT_EN
    if (v > lim) begin
      r.data = lim;
      r.sat  = 1;
    end else begin
      r.data = v;
      r.sat  = 0;
    end
`else
    r.data = v & lim;
    r.sat  = 0;
`endif
    return r;
  endfunction

  // One clock: observe at negedge, then advance the multiplier model after posedge.
  task automatic step();
    bit adv;
    @(negedge clk_i);
    cyc++;
    adv      = !stall_o;
    accepted = 0;
    if (!reset_i) begin
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("data", data_o, exp_q[0].data);
          check("count", count_o, exp_q[0].cnt);
          check("sat", sat_o, exp_q[0].sat);
          if (out_ready_i) begin
            last_data     = exp_q[0].data;
            last_sat      = exp_q[0].sat;
            last_cnt      = exp_q[0].cnt;
            last_xfer_cyc = cyc;
            xfers++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid_i && adv) begin
        accepted   = 1;
        accept_cyc = cyc;
        grp_sum   += longint'(op_prod);
        grp_cnt++;
        if (in_last_i || grp_cnt == ACC_LEN) begin
          exp_q.push_back(make_res(grp_sum, grp_cnt));
          grp_sum = 0;
          grp_cnt = 0;
        end
      end
    end
    @(posedge clk_i);
    #1;
    if (reset_i) begin
      exp_q.delete();
      grp_sum = 0;
      grp_cnt = 0;
    end
    if (adv) begin
      for (int i = MUL_LATENCY - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = op_prod;
    end
    data_p_i = pipe[MUL_LATENCY-1];
    if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input longint p, input bit last);
    in_valid_i = 1'b1;
    in_last_i  = last;
    op_prod    = P_WIDTH'(p);
    for (int k = 0; k < 200 && !accepted; k++) step();
    if (!accepted) check("send_timeout", 0, 1);
    accepted   = 0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_xfers(input int target);
    for (int k = 0; k < 300 && xfers < target; k++) step();
    check("xfer_count", xfers, target);
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    reset_i    = 1'b1;
    step();
    reset_i    = 1'b0;
    check("rst_valid", out_valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_sat", sat_o, 0);
    check("rst_count", count_o, 0);
    check("rst_stall", stall_o, 0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < MUL_LATENCY; i++) pipe[i] = '0;
    do_reset();

    // Full-length group without last, latency from final operands.
    out_ready_i = 1'b1;
    base = xfers;
    send(100, 0); send(200, 0); send(300, 0); send(400, 0);
    wait_xfers(base + 1);
    check("full_data", last_data, 63);
    check("full_count", last_cnt, 4);
    check("full_sat", last_sat, 0);
    check("latency", last_xfer_cyc - accept_cyc, MUL_LATENCY + 1);

    // Early last.
    base = xfers;
    send(16, 0); send(16, 0); send(17, 1);
    wait_xfers(base + 1);
    check("early_data", last_data, 3);
    check("early_count", last_cnt, 3);

    // One-product groups exercising round-half-up.
    base = xfers;
    send(24, 1);
    send(23, 1);
    wait_xfers(base + 2);
    check("round_dn_data", last_data, 1);
    check("round_dn_count", last_cnt, 1);

    // Overflow of the output width.
    base = xfers;
    for (int i = 0; i < 4; i++) send(1048575, 0);
    wait_xfers(base + 1);
`ifdef PROD_ACCUM_SAT_EN
    check("sat_data", last_data, 65535);
    check("sat_flag", last_sat, 1);
`else
    check("wrap_data", last_data, 0);
    check("wrap_flag", last_sat, 0);
`endif

    // Backpressure with a second group in flight.
    base = xfers;
    out_ready_i = 1'b0;
    send(10, 0); send(20, 1);
    send(30, 0); send(40, 0);
    repeat (8) step();
    check("bp_stall", stall_o, 1);
    check("bp_valid", out_valid_o, 1);
    check("bp_hold_data", data_o, 2);
    check("bp_hold_count", count_o, 2);
    out_ready_i = 1'b1;
    send(50, 1);
    wait_xfers(base + 2);
    check("bp_second_data", last_data, 8);
    check("bp_second_count", last_cnt, 3);

    // Reset in the middle of a group.
    send(7, 0); send(9, 0);
    step();
    do_reset();
    base = xfers;
    send(5, 0); send(5, 1);
    wait_xfers(base + 1);
    check("post_rst_data", last_data, 1);
    check("post_rst_count", last_cnt, 2);

    // Random traffic with random ready and stray last flags.
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) != 0) send($urandom_range(0, (1 << P_WIDTH) - 1), $urandom_range(0, 3) == 0);
        else send($urandom_range(0, 64), $urandom_range(0, 3) == 0);
      end else begin
        in_last_i = $urandom_range(0, 1);
        step();
        in_last_i = 1'b0;
      end
    end
    rand_ready  = 0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) step();
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
